// File: rtl/minmax_pkg.sv
// Shared types and ordering helper for the min/max tracker.
// Also usable by other compare-family blocks.
package minmax_pkg;

  localparam int unsigned MAXW = 64;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_e;

  // Signed order equals unsigned order once the sign bits are flipped.
  function automatic logic ord_lt(
    input logic [MAXW-1:0] a,
    input logic [MAXW-1:0] b,
    input logic            signed_mode,
    input int unsigned     w = MAXW
  );
    logic [MAXW-1:0] flip;
    flip = signed_mode ? (MAXW'(1) << (w - 1)) : '0;
    return (a ^ flip) < (b ^ flip);
  endfunction

endpackage

// File: rtl/window_minmax_if.sv
// Sample stream in, windowed min/max result out.
// master: sample producer / result consumer; slave: the tracker.
interface window_minmax_if #(
  parameter int WIDTH  = 32,
  parameter int WINDOW = 8
);
  localparam int IDXW = $clog2(WINDOW);
  localparam int CNTW = $clog2(WINDOW + 1);

  logic             signed_i;
  logic [WIDTH-1:0] data_i;
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] min_o;
  logic [WIDTH-1:0] max_o;
  logic [IDXW-1:0]  min_idx_o;
  logic [IDXW-1:0]  max_idx_o;
  logic [CNTW-1:0]  count_o;
  logic             result_valid_o;
  logic             result_ready_i;

  modport master (
    output signed_i, data_i, valid_i,
    output result_ready_i,
    input  ready_o, min_o, max_o,
    input  min_idx_o, max_idx_o,
    input  count_o, result_valid_o
  );

  modport slave (
    input  signed_i, data_i, valid_i,
    input  result_ready_i,
    output ready_o, min_o, max_o,
    output min_idx_o, max_idx_o,
    output count_o, result_valid_o
  );
endinterface

// File: rtl/minmax_cmp.sv
// Strict lt/gt of one sample against the running min and max.
// Ordering is the latched mode of the current window.
module minmax_cmp
  import minmax_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] cur_min,
  input  logic [WIDTH-1:0] cur_max,
  input  logic             signed_mode,
  output logic             lt,
  output logic             gt
);
  always_comb begin
    lt = ord_lt(MAXW'(data), MAXW'(cur_min),
                signed_mode, WIDTH);
    gt = ord_lt(MAXW'(cur_max), MAXW'(data),
                signed_mode, WIDTH);
  end
endmodule

// File: rtl/window_minmax.sv
// Windowed min/max tracker: FSM, counter, result regs, handshakes.
// WINDOW_MINMAX_IDX_EN adds the min/max position registers.
module window_minmax
  import minmax_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int WINDOW = 8
) (
  input logic            clk_i,
  input logic            rst_n_i,
  window_minmax_if.slave bus
);
  localparam int IDXW = $clog2(WINDOW);
  localparam int CNTW = $clog2(WINDOW + 1);

  if (WIDTH < 2 || WIDTH > 64 || WINDOW < 2) begin : g_bad
    $fatal(1, "window_minmax: bad WIDTH/WINDOW");
  end

  state_e           state_q, state_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic             mode_q, mode_d;

  logic accept;
  logic lt, gt;
  logic upd_min, upd_max;

  minmax_cmp #(.WIDTH(WIDTH)) u_cmp (
    .data        (bus.data_i),
    .cur_min     (min_q),
    .cur_max     (max_q),
    .signed_mode (mode_q),
    .lt          (lt),
    .gt          (gt)
  );

  assign bus.ready_o = (state_q != HOLD);
  assign accept      = bus.valid_i && bus.ready_o;
  // The first sample of a window seeds both extremes.
  assign upd_min = accept && (state_q == IDLE || lt);
  assign upd_max = accept && (state_q == IDLE || gt);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    min_d   = min_q;
    max_d   = max_q;
    mode_d  = mode_q;
    unique case (state_q)
      IDLE: if (accept) begin
        mode_d  = bus.signed_i;
        count_d = CNTW'(1);
        state_d = ACCUM;
      end
      ACCUM: if (accept) begin
        count_d = count_q + CNTW'(1);
        if (count_q == CNTW'(WINDOW - 1))
          state_d = HOLD;
      end
      HOLD: if (bus.result_ready_i) begin
        count_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (upd_min) min_d = bus.data_i;
    if (upd_max) max_d = bus.data_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      count_q <= '0;
      min_q   <= '0;
      max_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      min_q   <= min_d;
      max_q   <= max_d;
      mode_q  <= mode_d;
    end
  end

`ifdef WINDOW_MINMAX_IDX_EN
  logic [IDXW-1:0] min_idx_q, min_idx_d;
  logic [IDXW-1:0] max_idx_q, max_idx_d;
  logic [IDXW-1:0] pos;

  // count_q is zero in IDLE, so it is the position in both states.
  assign pos = count_q[IDXW-1:0];

  always_comb begin
    min_idx_d = min_idx_q;
    max_idx_d = max_idx_q;
    if (upd_min) min_idx_d = pos;
    if (upd_max) max_idx_d = pos;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      min_idx_q <= '0;
      max_idx_q <= '0;
    end else begin
      min_idx_q <= min_idx_d;
      max_idx_q <= max_idx_d;
    end
  end

  assign bus.min_idx_o = min_idx_q;
  assign bus.max_idx_o = max_idx_q;
`else
  assign bus.min_idx_o = '0;
  assign bus.max_idx_o = '0;
`endif

  assign bus.min_o          = min_q;
  assign bus.max_o          = max_q;
  assign bus.count_o        = count_q;
  assign bus.result_valid_o = (state_q == HOLD);
endmodule
